// File: rtl/result_write_arbiter_if.sv
// Lane-side write streams and frame-buffer pixel port of result_write_arbiter.
// master = lane array / frame-buffer side, slave = the arbiter.
interface result_write_arbiter_if #(
  parameter int unsigned NUM_PARALLEL = 4,
  parameter int unsigned WIDTH_BITS   = 8,
  parameter int unsigned HEIGHT_BITS  = 8
);
  logic [NUM_PARALLEL*WIDTH_BITS-1:0]  iCol;
  logic [NUM_PARALLEL*HEIGHT_BITS-1:0] iRow;
  logic [NUM_PARALLEL-1:0]             iData;
  logic [NUM_PARALLEL-1:0]             iWren;
  logic [NUM_PARALLEL-1:0]             oReady;
  logic [7:0]                          oX;
  logic [7:0]                          oY;
  logic [2:0]                          oR;
  logic [2:0]                          oG;
  logic [2:0]                          oB;
  logic                                oWren;
  logic                                oBusy;
  logic [NUM_PARALLEL-1:0]             oOverflow;
  logic [WIDTH_BITS+HEIGHT_BITS:0]     oWriteCount;

  modport master (
    output iCol, iRow, iData, iWren,
    input  oReady, oX, oY, oR, oG, oB, oWren, oBusy, oOverflow, oWriteCount
  );

  modport slave (
    input  iCol, iRow, iData, iWren,
    output oReady, oX, oY, oR, oG, oB, oWren, oBusy, oOverflow, oWriteCount
  );
endinterface

// File: rtl/result_write_arbiter.sv
// Per-lane result FIFOs drained round-robin, one pixel per clock, into the
// single frame-buffer write port.
module result_write_arbiter #(
  parameter int unsigned NUM_PARALLEL_BITS = 2,
  parameter int unsigned NUM_PARALLEL      = 2 ** NUM_PARALLEL_BITS,
  parameter int unsigned WIDTH_BITS        = 8,
  parameter int unsigned HEIGHT_BITS       = 8,
  parameter int unsigned FIFO_DEPTH_BITS   = 2
) (
  input logic                   clock,
  input logic                   reset,
  result_write_arbiter_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_BITS;
  localparam int unsigned EW    = HEIGHT_BITS + WIDTH_BITS + 1;

  typedef logic [NUM_PARALLEL_BITS-1:0] lane_t;
  typedef logic [FIFO_DEPTH_BITS-1:0]   fptr_t;
  typedef logic [FIFO_DEPTH_BITS:0]     cnt_t;
  typedef logic [EW-1:0]                entry_t;

  entry_t mem_q    [NUM_PARALLEL][DEPTH];
  fptr_t  wr_ptr_q [NUM_PARALLEL];
  fptr_t  rd_ptr_q [NUM_PARALLEL];
  cnt_t   count_q  [NUM_PARALLEL];
  cnt_t   count_d  [NUM_PARALLEL];

  logic [NUM_PARALLEL-1:0] nonempty;
  logic [NUM_PARALLEL-1:0] ready;
  logic [NUM_PARALLEL-1:0] push;
  logic [NUM_PARALLEL-1:0] drop;
  logic [NUM_PARALLEL-1:0] pop;
  logic [NUM_PARALLEL-1:0] overflow_q;

  lane_t  rr_ptr_q;
  lane_t  scan;
  lane_t  grant_idx;
  logic   grant_valid;
  entry_t head;

  logic [7:0]                      x_q;
  logic [7:0]                      y_q;
  logic                            pix_q;
  logic                            wren_q;
  logic [WIDTH_BITS+HEIGHT_BITS:0] wcount_q;

  // Readiness depends only on stored occupancy, so a full lane stays
  // blocked even in the cycle it is being popped.
  always_comb begin
    nonempty = '0;
    ready    = '0;
    push     = '0;
    drop     = '0;
    for (int unsigned i = 0; i < NUM_PARALLEL; i++) begin
      nonempty[i] = (count_q[i] != '0);
      ready[i]    = (count_q[i] != cnt_t'(DEPTH)) && !reset;
      push[i]     = bus.iWren[i] && ready[i];
      drop[i]     = bus.iWren[i] && !ready[i];
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan        = rr_ptr_q;
    for (int unsigned k = 0; k < NUM_PARALLEL; k++) begin
      scan = rr_ptr_q + lane_t'(k);
      if (!grant_valid && nonempty[scan]) begin
        grant_valid = 1'b1;
        grant_idx   = scan;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < NUM_PARALLEL; i++) begin
      pop[i]     = grant_valid && (grant_idx == lane_t'(i));
      count_d[i] = count_q[i] + cnt_t'(push[i]) - cnt_t'(pop[i]);
    end
  end

  assign head = mem_q[grant_idx][rd_ptr_q[grant_idx]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PARALLEL; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      overflow_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PARALLEL; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        count_q[i] <= count_d[i];
        if (drop[i]) overflow_q[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NUM_PARALLEL; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= {bus.iRow[i*HEIGHT_BITS +: HEIGHT_BITS],
                                  bus.iCol[i*WIDTH_BITS +: WIDTH_BITS],
                                  bus.iData[i]};
      end
    end
  end

  // Frame-buffer x comes from the lane row, y from the lane column.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      pix_q    <= 1'b0;
      wren_q   <= 1'b0;
      wcount_q <= '0;
    end else begin
      wren_q <= grant_valid;
      if (grant_valid) begin
        x_q      <= 8'(head[EW-1 -: HEIGHT_BITS]);
        y_q      <= 8'(head[WIDTH_BITS:1]);
        pix_q    <= head[0];
        rr_ptr_q <= grant_idx + 1'b1;
        wcount_q <= wcount_q + 1'b1;
      end
    end
  end

  assign bus.oReady      = ready;
  assign bus.oX          = x_q;
  assign bus.oY          = y_q;
  assign bus.oR          = {3{pix_q}};
  assign bus.oG          = {3{pix_q}};
  assign bus.oB          = {3{pix_q}};
  assign bus.oWren       = wren_q;
  assign bus.oBusy       = (|nonempty) || wren_q;
  assign bus.oOverflow   = overflow_q;
  assign bus.oWriteCount = wcount_q;
endmodule

// File: tb/tb_result_write_arbiter.sv
// Self-checking bench for result_write_arbiter: directed table, multi-cycle
// corner sequences and randomized traffic against a queue-based model.
module tb_result_write_arbiter;
  localparam int N = 4;
  localparam int D = 4;

  logic clk;
  logic rst;

  result_write_arbiter_if #(.NUM_PARALLEL(4), .WIDTH_BITS(8), .HEIGHT_BITS(8)) bus ();

  result_write_arbiter #(
    .NUM_PARALLEL_BITS(2),
    .WIDTH_BITS(8),
    .HEIGHT_BITS(8),
    .FIFO_DEPTH_BITS(2)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Reference model: one queue per lane, round-robin pointer, output regs.
  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
    logic       d;
  } ent_t;

  ent_t        mq [N][$];
  int          m_ptr;
  logic        m_wren;
  logic [7:0]  m_x;
  logic [7:0]  m_y;
  logic        m_d;
  logic [16:0] m_cnt;
  logic [3:0]  m_ovf;

  task automatic model_reset();
    for (int l = 0; l < N; l++) mq[l].delete();
    m_ptr  = 0;
    m_wren = 1'b0;
    m_x    = '0;
    m_y    = '0;
    m_d    = 1'b0;
    m_cnt  = '0;
    m_ovf  = '0;
  endtask

  function automatic logic model_busy();
    logic b;
    b = m_wren;
    for (int l = 0; l < N; l++) if (mq[l].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic clear_inputs();
    bus.iWren = '0;
    bus.iRow  = '0;
    bus.iCol  = '0;
    bus.iData = '0;
  endtask

  task automatic set_lane(input int l, input logic [7:0] r, input logic [7:0] c, input logic d);
    bus.iWren[l]       = 1'b1;
    bus.iRow[l*8 +: 8] = r;
    bus.iCol[l*8 +: 8] = c;
    bus.iData[l]       = d;
  endtask

  task automatic do_edge();
    logic [3:0] rdy;
    int         g;
    int         l;
    ent_t       e;
    #1;
    for (int i = 0; i < N; i++) rdy[i] = (mq[i].size() < D);
    check("oReady", 32'(bus.oReady), 32'(rdy));
    check("oBusy_pre", 32'(bus.oBusy), 32'(model_busy()));
    g = -1;
    for (int k = 0; k < N; k++) begin
      l = (m_ptr + k) % N;
      if (g < 0 && mq[l].size() != 0) g = l;
    end
    if (g >= 0) begin
      e      = mq[g].pop_front();
      m_wren = 1'b1;
      m_x    = e.row;
      m_y    = e.col;
      m_d    = e.d;
      m_ptr  = (g + 1) % N;
      m_cnt  = m_cnt + 17'd1;
    end else begin
      m_wren = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (bus.iWren[i]) begin
        if (rdy[i]) mq[i].push_back('{row: bus.iRow[i*8 +: 8], col: bus.iCol[i*8 +: 8], d: bus.iData[i]});
        else m_ovf[i] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("oWren", 32'(bus.oWren), 32'(m_wren));
    check("oX", 32'(bus.oX), 32'(m_x));
    check("oY", 32'(bus.oY), 32'(m_y));
    check("oR", 32'(bus.oR), 32'({3{m_d}}));
    check("oG", 32'(bus.oG), 32'({3{m_d}}));
    check("oB", 32'(bus.oB), 32'({3{m_d}}));
    check("oWriteCount", 32'(bus.oWriteCount), 32'(m_cnt));
    check("oOverflow", 32'(bus.oOverflow), 32'(m_ovf));
    check("oBusy", 32'(bus.oBusy), 32'(model_busy()));
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  wren;
    logic [7:0]  row_base;
    logic [7:0]  col_base;
    logic [3:0]  data;
    logic        exp_wren;
    logic [7:0]  exp_x;
    logic [7:0]  exp_y;
    logic [2:0]  exp_rgb;
    logic [16:0] exp_cnt;
    logic        exp_busy;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [3:0] w, input logic [7:0] rb, input logic [7:0] cb,
                     input logic [3:0] d, input logic ew, input logic [7:0] ex, input logic [7:0] ey,
                     input logic [2:0] ergb, input logic [16:0] ecnt, input logic eb);
    vec_t v;
    v.rst = r; v.wren = w; v.row_base = rb; v.col_base = cb; v.data = d;
    v.exp_wren = ew; v.exp_x = ex; v.exp_y = ey; v.exp_rgb = ergb; v.exp_cnt = ecnt; v.exp_busy = eb;
    vq.push_back(v);
  endtask

  logic [7:0] fair_x [8];

  initial begin
    vec_t v;
    int   rate;

    rst = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_oWren", 32'(bus.oWren), 32'(0));
    check("rst_oX", 32'(bus.oX), 32'(0));
    check("rst_oReady", 32'(bus.oReady), 32'(0));
    check("rst_oBusy", 32'(bus.oBusy), 32'(0));
    check("rst_oWriteCount", 32'(bus.oWriteCount), 32'(0));
    rst = 1'b0;

    // Single-lane latency, then a four-lane collision from a fresh pointer.
    add(1, 4'b0000,  0,  0, 4'b0000, 0,  0,  0, 3'b000, 0, 0);
    add(0, 4'b0001,  5,  7, 4'b0001, 0,  0,  0, 3'b000, 0, 1);
    add(0, 4'b0000,  0,  0, 4'b0000, 1,  5,  7, 3'b111, 1, 1);
    add(0, 4'b0000,  0,  0, 4'b0000, 0,  5,  7, 3'b111, 1, 0);
    add(1, 4'b0000,  0,  0, 4'b0000, 0,  0,  0, 3'b000, 0, 0);
    add(0, 4'b1111, 10, 20, 4'b0101, 0,  0,  0, 3'b000, 0, 1);
    add(0, 4'b0000,  0,  0, 4'b0000, 1, 10, 20, 3'b111, 1, 1);
    add(0, 4'b0000,  0,  0, 4'b0000, 1, 11, 21, 3'b000, 2, 1);
    add(0, 4'b0000,  0,  0, 4'b0000, 1, 12, 22, 3'b111, 3, 1);
    add(0, 4'b0000,  0,  0, 4'b0000, 1, 13, 23, 3'b000, 4, 1);
    add(0, 4'b0000,  0,  0, 4'b0000, 0, 13, 23, 3'b000, 4, 0);

    for (int j = 0; j < vq.size(); j++) begin
      v = vq[j];
      clear_inputs();
      if (v.rst) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("tbl%0d_oReady", j), 32'(bus.oReady), 32'(0));
        rst = 1'b0;
        model_reset();
      end else begin
        for (int l = 0; l < N; l++)
          if (v.wren[l]) set_lane(l, 8'(v.row_base + 8'(l)), 8'(v.col_base + 8'(l)), v.data[l]);
        do_edge();
      end
      check($sformatf("tbl%0d_oWren", j), 32'(bus.oWren), 32'(v.exp_wren));
      check($sformatf("tbl%0d_oX", j), 32'(bus.oX), 32'(v.exp_x));
      check($sformatf("tbl%0d_oY", j), 32'(bus.oY), 32'(v.exp_y));
      check($sformatf("tbl%0d_oR", j), 32'(bus.oR), 32'(v.exp_rgb));
      check($sformatf("tbl%0d_cnt", j), 32'(bus.oWriteCount), 32'(v.exp_cnt));
      check($sformatf("tbl%0d_oBusy", j), 32'(bus.oBusy), 32'(v.exp_busy));
      check($sformatf("tbl%0d_ovf", j), 32'(bus.oOverflow), 32'(0));
    end

    // Fairness: lanes 0 and 2 each push four entries back-to-back.
    fair_x = '{8'h00, 8'h20, 8'h01, 8'h21, 8'h02, 8'h22, 8'h03, 8'h23};
    apply_reset();
    for (int j = 0; j < 10; j++) begin
      clear_inputs();
      if (j < 4) begin
        set_lane(0, 8'(j), 8'h50, 1'b1);
        set_lane(2, 8'(8'h20 + 8'(j)), 8'h60, 1'b0);
      end
      do_edge();
      if (j >= 1 && j <= 8) begin
        check($sformatf("fair%0d_oX", j), 32'(bus.oX), 32'(fair_x[j-1]));
        check($sformatf("fair%0d_oWren", j), 32'(bus.oWren), 32'(1));
      end
    end
    check("fair_idle_oWren", 32'(bus.oWren), 32'(0));

    // Overflow: lane 1 is granted once, then fills while 2, 3, 0 take turns.
    apply_reset();
    for (int j = 0; j < 6; j++) begin
      clear_inputs();
      set_lane(1, 8'(8'h10 + 8'(j)), 8'(8'h40 + 8'(j)), 1'b1);
      if (j == 0) begin
        set_lane(2, 8'h30, 8'h70, 1'b0);
        set_lane(3, 8'h31, 8'h71, 1'b1);
      end
      if (j == 1) set_lane(0, 8'h32, 8'h72, 1'b0);
      if (j == 5) begin
        #1;
        check("ovf_ready_full", 32'(bus.oReady), 32'(4'b1101));
        check("ovf_not_yet", 32'(bus.oOverflow), 32'(0));
      end
      do_edge();
    end
    check("ovf_flag", 32'(bus.oOverflow), 32'(4'b0010));
    clear_inputs();
    repeat (6) do_edge();
    check("ovf_count", 32'(bus.oWriteCount), 32'(8));
    check("ovf_idle_busy", 32'(bus.oBusy), 32'(0));

    // Idle hold: last granted pixel stays, pointer resumes after lane 1.
    check("hold_oWren", 32'(bus.oWren), 32'(0));
    check("hold_oX", 32'(bus.oX), 32'(8'h14));
    check("hold_oY", 32'(bus.oY), 32'(8'h44));
    set_lane(0, 8'h60, 8'h61, 1'b1);
    set_lane(3, 8'h63, 8'h64, 1'b0);
    do_edge();
    clear_inputs();
    check("hold2_oX", 32'(bus.oX), 32'(8'h14));
    do_edge();
    check("rr_after_idle_lane3", 32'(bus.oX), 32'(8'h63));
    do_edge();
    check("rr_after_idle_lane0", 32'(bus.oX), 32'(8'h60));
    do_edge();

    // Reset mid-drain with three entries still queued.
    for (int l = 0; l < N; l++) set_lane(l, 8'(8'h70 + 8'(l)), 8'h11, 1'b1);
    do_edge();
    clear_inputs();
    do_edge();
    check("md_pre_wren", 32'(bus.oWren), 32'(1));
    #3;
    rst = 1'b1;
    #1;
    check("md_oWren", 32'(bus.oWren), 32'(0));
    check("md_oBusy", 32'(bus.oBusy), 32'(0));
    check("md_oWriteCount", 32'(bus.oWriteCount), 32'(0));
    check("md_oOverflow", 32'(bus.oOverflow), 32'(0));
    check("md_oReady", 32'(bus.oReady), 32'(0));
    check("md_oX", 32'(bus.oX), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check("md_release_ready", 32'(bus.oReady), 32'(4'b1111));
    for (int j = 0; j < 4; j++) begin
      do_edge();
      check($sformatf("md_stale%0d", j), 32'(bus.oWren), 32'(0));
    end

    // Randomized traffic at light, saturating and sparse request rates.
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      rate = (c < 200) ? 30 : (c < 400) ? 90 : 15;
      clear_inputs();
      for (int l = 0; l < N; l++)
        if ($urandom_range(99) < rate) set_lane(l, 8'($urandom), 8'($urandom), 1'($urandom));
      do_edge();
    end
    clear_inputs();
    repeat (20) do_edge();
    check("rand_drained_busy", 32'(bus.oBusy), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
